// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped read-only instruction cache with fixed-latency line refill
// Saturating hit/miss statistics; flush invalidates all lines while idle.
module icache_fetch #(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 8
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         cpuReq,
    input  logic [31:0]  cpuAddress,
    output logic         cpuReady,
    output logic         cpuValid,
    output logic [31:0]  cpuData,
    input  logic         flush,
    output logic [31:0]  memAddress,
    input  logic [127:0] memData,
    output logic [15:0]  hitCount,
    output logic [15:0]  missCount
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = 28 - IDX;
    localparam int CW  = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;

    logic [1:0]     state;
    logic [31:0]    req_addr;
    logic [CW-1:0]  lat_cnt;
    logic [LINES-1:0] valid;
    logic [TW-1:0]  tags  [LINES];
    logic [127:0]   lines [LINES];

    logic [IDX-1:0] idx;
    logic [TW-1:0]  tag;
    logic [1:0]     off;
    logic           hit;
    logic           fill_done;

    assign idx       = req_addr[4+IDX-1:4];
    assign tag       = req_addr[31:4+IDX];
    assign off       = req_addr[3:2];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign fill_done = (state == ST_FILL) && (lat_cnt == CW'(MEM_LATENCY - 1));
    assign cpuReady  = (state == ST_IDLE) && !flush;

    // Word 0 sits in the most significant 32 bits of a line.
    function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
        logic [31:0] r;
        case (w)
            2'd0:    r = line[127:96];
            2'd1:    r = line[95:64];
            2'd2:    r = line[63:32];
            default: r = line[31:0];
        endcase
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            req_addr   <= '0;
            lat_cnt    <= '0;
            valid      <= '0;
            cpuValid   <= 1'b0;
            cpuData    <= '0;
            memAddress <= '0;
            hitCount   <= '0;
            missCount  <= '0;
        end else begin
            cpuValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (cpuReq) begin
                        req_addr <= {cpuAddress[31:2], 2'b00};
                        state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        cpuData  <= sel_word(lines[idx], off);
                        cpuValid <= 1'b1;
                        if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
                        state    <= ST_IDLE;
                    end else begin
                        memAddress <= {req_addr[31:4], 4'b0000};
                        lat_cnt    <= '0;
                        if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
                        state      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    lat_cnt <= lat_cnt + CW'(1);
                    if (fill_done) begin
                        valid[idx] <= 1'b1;
                        cpuData    <= sel_word(memData, off);
                        cpuValid   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array contents need no reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (resetN && fill_done) begin
            lines[idx] <= memData;
            tags[idx]  <= tag;
        end
    end
endmodule
